// File: rtl/apb_reg_arbiter.sv
// rtl/apb_reg_arbiter.sv - round-robin arbiter sharing one APB register bus between requesters
//
// Purpose: grants one of NUM_REQ requesters at a time and runs its transfer
// through APB SETUP/ACCESS. It then returns read data and error status to the
// winner with a one-cycle ack pulse.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req[NUM_REQ]           per-requester request, held until its ack
//   req_write[NUM_REQ]     1 = write, 0 = read
//   req_addr[NUM_REQ][32]  per-requester address
//   req_wdata[NUM_REQ][32] per-requester write data
//   ack[NUM_REQ]           one-cycle completion pulse, one-hot or zero
//   rsp_rdata[32]          read data of the completed transfer (0 for writes)
//   rsp_err                pslverr / timeout status of the completed transfer
//   psel, penable, pwrite, paddr, pwdata   APB master outputs
//   pready, prdata, pslverr                APB slave responses
//
// Optional feature: define APB_ARB_TIMEOUT_EN to enable the ACCESS-phase timeout.
// The timeout completes the transfer after TIMEOUT_CYCLES ACCESS cycles
// without pready.
module apb_reg_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0] req_wdata,
  output logic [NUM_REQ-1:0]       ack,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [31:0]              paddr,
  output logic [31:0]              pwdata,
  input  logic                     pready,
  input  logic [31:0]              prdata,
  input  logic                     pslverr
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hBADD_C0DE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_last_grant;
  logic [IDX_W-1:0]    r_grant;
  logic                r_write;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic                r_psel;
  logic                r_penable;
  logic [NUM_REQ-1:0]  r_ack;

  logic [NUM_REQ-1:0]  w_eligible;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic                w_found;
  logic [IDX_W-1:0]    w_pick;
  logic [IDX_W-1:0]    w_cand;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]    r_cnt;
`else
  // TIMEOUT_CYCLES has no effect in this build; only its legal range is referenced.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_unused
  end
`endif

  // The requester being acked this cycle may still hold req; keep it out of the search.
  assign w_eligible = req & ~r_ack;
  assign w_grant_oh = NUM_REQ'(1) << r_grant;

  // Round-robin search starting one past the last grant, wrapping at NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = IDX_W'((int'(r_last_grant) + 1 + i) % NUM_REQ);
      if (!w_found && w_eligible[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= LAST_IDX;
      r_grant      <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_ack        <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      r_cnt        <= '0;
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_write      <= req_write[w_pick];
            r_addr       <= req_addr[w_pick];
            r_wdata      <= req_wdata[w_pick];
            r_psel       <= 1'b1;
            r_state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          r_cnt     <= '0;
`endif
        end
        S_ACCESS: begin
          if (pready) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_ack     <= w_grant_oh;
            r_rdata   <= r_write ? '0 : prdata;
            r_err     <= pslverr;
            r_state   <= S_IDLE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          // r_cnt holds the number of completed ACCESS cycles before this one.
          else if (r_cnt == CNT_LAST) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_ack     <= w_grant_oh;
            r_rdata   <= TIMEOUT_DATA;
            r_err     <= 1'b1;
            r_state   <= S_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_write;
  assign paddr     = r_addr;
  assign pwdata    = r_wdata;

endmodule

// File: tb/tb_apb_reg_arbiter.sv
// tb/tb_apb_reg_arbiter.sv - scoreboard bench for apb_reg_arbiter with randomized requesters
module tb_apb_reg_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam logic [31:0] BAD = 32'hBADD_C0DE;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req = '0;
  logic [N-1:0]        req_write = '0;
  logic [N-1:0][31:0]  req_addr = '0;
  logic [N-1:0][31:0]  req_wdata = '0;
  logic [N-1:0]        ack;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic                psel, penable, pwrite;
  logic [31:0]         paddr, pwdata;
  logic                pready = 1'b0;
  logic [31:0]         prdata = '0;
  logic                pslverr = 1'b0;

  apb_reg_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; } apb_t;

  rsp_t        exp_rsp[$];
  apb_t        exp_apb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem_model[16];
  logic [31:0] slv_mem[16];
  int          model_last = N - 1;
  int          force_wait = -1;
  bit          stuck = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit unmapped(input logic [31:0] a);
    return (a == 32'h4) || a[31];
  endfunction

  task automatic push_apb(input bit wr, input logic [31:0] a, input logic [31:0] wd);
    apb_t t;
    t.wr = wr; t.addr = a; t.wdata = wd;
    exp_apb.push_back(t);
  endtask

  // Reference model: transfers complete in grant order against a flat register array.
  task automatic predict(input int idx, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    rsp_t r;
    bit   e;
    e = unmapped(a);
    push_apb(wr, a, wd);
    r.idx   = idx;
    r.err   = e;
    r.rdata = wr ? 32'h0 : (e ? BAD : mem_model[a[5:2]]);
    if (wr && !e) mem_model[a[5:2]] = wd;
    exp_rsp.push_back(r);
    model_last = idx;
  endtask

  // Response monitor.
  initial begin : monitor
    rsp_t         e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (rst_n && ack !== '0) begin
        if (exp_rsp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: got ack=%b expected none", ack);
        end else begin
          e = exp_rsp.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          check("ack_index", 32'(ack), 32'(oh));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  // APB slave with random or forced wait states; checks bus stability through ACCESS.
  initial begin : slave
    apb_t t, ex;
    int   w;
    bit   ok;
    forever begin
      @(posedge clk); #1;
      if (psel && !penable) begin
        t.wr = pwrite; t.addr = paddr; t.wdata = pwdata;
        if (exp_apb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_transfer: got addr %h expected none", paddr);
        end else begin
          ex = exp_apb.pop_front();
          check("apb_pwrite", 32'(t.wr), 32'(ex.wr));
          check("apb_paddr", t.addr, ex.addr);
          if (ex.wr) check("apb_pwdata", t.wdata, ex.wdata);
        end
        w = stuck ? 1000000 : ((force_wait >= 0) ? force_wait : $urandom_range(0, 3));
        @(posedge clk); #1;
        ok = 1'b1;
        for (int k = 0; k < w; k++) begin
          if (!(psel && penable)) begin
            ok = 1'b0;
            break;
          end
          check("stable_paddr", paddr, t.addr);
          check("stable_pwdata", pwdata, t.wdata);
          @(posedge clk); #1;
        end
        if (ok && psel && penable) begin
          check("stable_paddr", paddr, t.addr);
          check("stable_pwdata", pwdata, t.wdata);
          pready  = 1'b1;
          pslverr = unmapped(paddr);
          prdata  = pslverr ? BAD : slv_mem[paddr[5:2]];
          if (pwrite && !pslverr) slv_mem[paddr[5:2]] = pwdata;
          @(posedge clk); #1;
          pready  = 1'b0;
          pslverr = 1'b0;
          prdata  = $urandom();
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_last = N - 1;
  endtask

  // Drive one request at cycle 0 and measure the cycle its ack appears.
  task automatic launch(input int idx, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat);
    int n;
    bit got;
    @(posedge clk); #1;
    req_write[idx] = wr;
    req_addr[idx]  = a;
    req_wdata[idx] = wd;
    req[idx]       = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < exp_lat + 20 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check("setup_phase", {30'b0, psel, penable}, 32'b10);
      if (n == 2) check("access_phase", {30'b0, psel, penable}, 32'b11);
      if (ack[idx]) got = 1'b1;
    end
    req[idx] = 1'b0;
    check("ack_latency", n, exp_lat);
  endtask

  task automatic single(input int idx, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int waits);
    force_wait = waits;
    predict(idx, wr, a, wd);
    launch(idx, wr, a, wd, waits + 3);
    force_wait = -1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [N-1:0]  mask;
    logic [31:0]   fa[N];
    logic [31:0]   fd[N];
    bit            fw[N];
    int            start, ii, n, cnt, r, first_idx;
    int            t_ack[5];
    rsp_t          rt;

    for (int i = 0; i < 16; i++) begin
      mem_model[i] = $urandom();
      slv_mem[i]   = mem_model[i];
    end
    mem_model[2] = 32'h5;
    slv_mem[2]   = 32'h5;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_psel_penable", {30'b0, psel, penable}, 32'h0);
    check("rst_pwrite", 32'(pwrite), 32'h0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    rst_n = 1'b1;

    // Directed transfers: zero-wait read, 3-wait write, error read.
    single(0, 1'b0, 32'h8, 32'h0, 0);
    single(1, 1'b1, 32'h0, 32'h7F, 3);
    single(2, 1'b0, 32'h4, 32'h0, 0);

    // All requesters held continuously from reset: 0,1,2,3,0 with acks 3 cycles apart.
    do_reset();
    force_wait = 0;
    for (int i = 0; i < N; i++) begin
      fw[i] = 1'($urandom_range(0, 1));
      fa[i] = {26'b0, 4'($urandom_range(8, 15)), 2'b00};
      fd[i] = $urandom();
      req_write[i] = fw[i]; req_addr[i] = fa[i]; req_wdata[i] = fd[i];
    end
    for (int k = 0; k < 5; k++) predict(k % N, fw[k % N], fa[k % N], fd[k % N]);
    @(posedge clk); #1;
    req = '1;
    n = 0;
    cnt = 0;
    while (cnt < 5 && n < 80) begin
      @(posedge clk); #1;
      n++;
      if (ack != '0) begin
        t_ack[cnt] = n;
        cnt++;
        if (cnt == 5) req = '0;
      end
    end
    req = '0;
    check("rr_ack_count", cnt, 5);
    check("rr_first_ack", t_ack[0], 3);
    for (int k = 1; k < 5; k++) check("rr_ack_spacing", t_ack[k] - t_ack[k-1], 3);
    force_wait = -1;

    // Reset during ACCESS of req[2]: no ack, then req[0] wins first.
    do_reset();
    stuck = 1'b1;
    push_apb(1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    req_write[2] = 1'b0; req_addr[2] = 32'h10; req_wdata[2] = 32'h0;
    req[2] = 1'b1;
    n = 0;
    while (!(psel && penable) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reached_access", {30'b0, psel, penable}, 32'b11);
    #2 rst_n = 1'b0;
    #1;
    check("abort_psel_penable", {30'b0, psel, penable}, 32'h0);
    check("abort_ack", 32'(ack), 32'h0);
    stuck = 1'b0;
    req_write[0] = 1'b1; req_addr[0] = 32'h14; req_wdata[0] = $urandom();
    req[0] = 1'b1;
    model_last = N - 1;
    predict(0, 1'b1, 32'h14, req_wdata[0]);
    predict(2, 1'b0, 32'h10, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    first_idx = -1;
    while (req != '0 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (first_idx < 0 && ack != '0) first_idx = (ack == 4'b0001) ? 0 : 9;
      req = req & ~ack;
    end
    check("abort_first_winner", first_idx, 0);
    check("abort_round_done", 32'(req), 32'h0);

    // Slave never asserts pready.
    do_reset();
    stuck = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
    push_apb(1'b0, 32'h20, 32'h0);
    rt.idx = 1; rt.rdata = BAD; rt.err = 1'b1;
    exp_rsp.push_back(rt);
    launch(1, 1'b0, 32'h20, 32'h0, TO + 2);
    stuck = 1'b0;
    do_reset();
`else
    push_apb(1'b0, 32'h20, 32'h0);
    @(posedge clk); #1;
    req_write[1] = 1'b0; req_addr[1] = 32'h20; req_wdata[1] = 32'h0;
    req[1] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (ack != '0) cnt++;
    end
    check("stuck_no_ack", cnt, 0);
    check("stuck_still_access", {30'b0, psel, penable}, 32'b11);
    stuck = 1'b0;
    do_reset();
`endif

    // Randomized rounds of simultaneous requests.
    for (int rnd = 0; rnd < 40; rnd++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 9);
        fw[i] = 1'($urandom_range(0, 1));
        fd[i] = $urandom();
        if (r == 0)      fa[i] = 32'h8000_0000 | {26'b0, 4'($urandom_range(0, 15)), 2'b00};
        else if (r == 1) fa[i] = 32'h4;
        else             fa[i] = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      end
      start = model_last;
      for (int k = 0; k < N; k++) begin
        ii = (start + 1 + k) % N;
        if (mask[ii]) predict(ii, fw[ii], fa[ii], fd[ii]);
      end
      for (int i = 0; i < N; i++) begin
        req_write[i] = fw[i]; req_addr[i] = fa[i]; req_wdata[i] = fd[i];
      end
      req = mask;
      n = 0;
      while (req != '0 && n < 200) begin
        @(posedge clk); #1;
        n++;
        req = req & ~ack;
      end
      if (req != '0) check("random_round_done", 32'(req), 32'h0);
      req = '0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    check("rsp_queue_drained", exp_rsp.size(), 0);
    check("apb_queue_drained", exp_apb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
